// File: rtl/adc_bcd_avg.sv
// Block-averages ADC samples and, on each 1 s tick, converts the latest average
// into 4-digit packed BCD with a 12-cycle shift-add-3 sequence.
module adc_bcd_avg #(
  parameter int NAVG_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] adc_dat,
  input  logic        adc_vld,
  input  logic        ce1s,
  output logic [15:0] dat,
  output logic        dat_vld,
  output logic        busy
);

  localparam int ACC_W = 12 + NAVG_LOG2;
  // A one-sample block still needs a legal counter width; it simply stays at zero.
  localparam int CNT_W = (NAVG_LOG2 > 0) ? NAVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << NAVG_LOG2) - 1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  logic [ACC_W-1:0] acc_q, acc_d, sum;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [11:0]      avg_q, avg_d;
  state_t           state_q, state_d;
  logic [11:0]      bin_q, bin_d;
  logic [15:0]      bcd_q, bcd_d, bcd_adj;
  logic [3:0]       iter_q, iter_d;
  logic [15:0]      dat_q, dat_d;
  logic             dat_vld_q, dat_vld_d;

  function automatic logic [15:0] add3(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int k = 0; k < 4; k++) begin
      if (r[4*k +: 4] >= 4'd5) r[4*k +: 4] = r[4*k +: 4] + 4'd3;
    end
    return r;
  endfunction

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can infer a latch.
    sum   = acc_q + ACC_W'(adc_dat);
    acc_d = acc_q;
    cnt_d = cnt_q;
    avg_d = avg_q;
    if (adc_vld) begin
      if (cnt_q == CNT_LAST) begin
        avg_d = 12'(sum >> NAVG_LOG2);
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    iter_d    = iter_q;
    dat_d     = dat_q;
    dat_vld_d = 1'b0;
    bcd_adj   = add3(bcd_q);
    case (state_q)
      IDLE: begin
        if (ce1s) begin
          state_d = CONV;
          bin_d   = avg_q;
          bcd_d   = '0;
          iter_d  = '0;
        end
      end
      CONV: begin
        {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
        iter_d         = iter_q + 4'd1;
        if (iter_q == 4'd11) state_d = DONE;
      end
      DONE: begin
        dat_d     = bcd_q;
        dat_vld_d = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      avg_q     <= '0;
      state_q   <= IDLE;
      bin_q     <= '0;
      bcd_q     <= '0;
      iter_q    <= '0;
      dat_q     <= '0;
      dat_vld_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      avg_q     <= avg_d;
      state_q   <= state_d;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      iter_q    <= iter_d;
      dat_q     <= dat_d;
      dat_vld_q <= dat_vld_d;
    end
  end

  assign dat     = dat_q;
  assign dat_vld = dat_vld_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_adc_bcd_avg.sv
// Directed bench for adc_bcd_avg: averaging, BCD conversion timing, busy/ce1s
// interaction and mid-conversion reset, with hand-computed expected values.
module tb_adc_bcd_avg;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] adc_dat;
  logic        adc_vld;
  logic        ce1s;
  logic [15:0] dat;
  logic        dat_vld;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  adc_bcd_avg #(.NAVG_LOG2(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .adc_dat (adc_dat),
    .adc_vld (adc_vld),
    .ce1s    (ce1s),
    .dat     (dat),
    .dat_vld (dat_vld),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic send(input logic [11:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      adc_dat = v;
      adc_vld = 1'b1;
      tick();
    end
    adc_vld = 1'b0;
  endtask

  // Raises ce1s for one edge, optionally raises it again on edge second_at,
  // then checks 13 busy cycles, no early dat_vld, and the result after edge 14.
  task automatic run_conv(input string tag, input logic [15:0] exp, input int second_at);
    int busy_cnt;
    int vld_cnt;
    busy_cnt = 0;
    vld_cnt  = 0;
    ce1s = 1'b1;
    tick();
    ce1s    = 1'b0;
    adc_vld = 1'b0;
    if (busy) busy_cnt++;
    if (dat_vld) vld_cnt++;
    for (int i = 2; i <= 13; i++) begin
      ce1s = (i == second_at);
      tick();
      if (busy) busy_cnt++;
      if (dat_vld) vld_cnt++;
    end
    ce1s = 1'b0;
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd13);
    check({tag, "_early_vld"}, 32'(vld_cnt), 32'd0);
    tick();
    check({tag, "_dat"}, 32'(dat), 32'(exp));
    check({tag, "_vld"}, 32'(dat_vld), 32'd1);
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
    tick();
    check({tag, "_vld_one_cycle"}, 32'(dat_vld), 32'd0);
    check({tag, "_dat_hold"}, 32'(dat), 32'(exp));
  endtask

  initial begin
    int vld_cnt;
    rst     = 1'b1;
    adc_dat = '0;
    adc_vld = 1'b0;
    ce1s    = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_dat", 32'(dat), 32'h0000);
    check("rst_vld", 32'(dat_vld), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    send(12'd1234, 16);
    run_conv("avg1234", 16'h1234, 0);

    send(12'd4095, 16);
    run_conv("avg4095", 16'h4095, 0);

    send(12'd0, 16);
    run_conv("avg0", 16'h0000, 0);

    // 16024 / 16 = 1001.5, truncated to 1001
    send(12'd1000, 8);
    send(12'd1003, 8);
    run_conv("trunc", 16'h1001, 0);

    // Second tick while busy must be ignored: same result, single pulse.
    run_conv("ignore_ce", 16'h1001, 6);
    for (int i = 0; i < 16; i++) begin
      tick();
      if (dat_vld) check("ignore_ce_no_restart", 32'(dat_vld), 32'd0);
    end
    check("ignore_ce_idle", 32'(busy), 32'd0);

    // Block completing on the ce1s edge: old average converted first.
    send(12'd100, 16);
    send(12'd200, 15);
    adc_dat = 12'd200;
    adc_vld = 1'b1;
    run_conv("coincide_old", 16'h0100, 0);
    run_conv("coincide_new", 16'h0200, 0);

    // Reset 6 cycles into CONV, with ce1s and a sample colliding on the reset edge.
    send(12'd777, 16);
    send(12'd50, 5);
    ce1s = 1'b1;
    tick();
    ce1s = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst     = 1'b1;
    ce1s    = 1'b1;
    adc_dat = 12'd4095;
    adc_vld = 1'b1;
    tick();
    rst     = 1'b0;
    ce1s    = 1'b0;
    adc_vld = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_dat", 32'(dat), 32'h0000);
    vld_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (dat_vld) vld_cnt++;
    end
    check("abort_no_vld", 32'(vld_cnt), 32'd0);
    check("abort_dat_hold", 32'(dat), 32'h0000);

    run_conv("avg_after_rst", 16'h0000, 0);
    send(12'd300, 16);
    run_conv("partial_discard", 16'h0300, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
